// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture monitor and the display encoder.
// Holds segment codes (gfedcba, active-high), FSM states and SEL position indices.
package seg_scan_capture_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam int POS_MIN_U  = 0;
   localparam int POS_MIN_T  = 1;
   localparam int POS_HOUR_U = 2;
   localparam int POS_HOUR_T = 3;

   typedef enum logic [1:0] {
      SCAN   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } scan_state_e;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      case (v)
         4'b0010: idx = 2'(POS_MIN_T);
         4'b0100: idx = 2'(POS_HOUR_U);
         4'b1000: idx = 2'(POS_HOUR_T);
         default: idx = 2'(POS_MIN_U);
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/seg_scan_capture_seg7_to_bcd.sv
// Combinational 7-segment (normalised gfedcba) to BCD digit decoder.
// Blank decodes to 0 without error; unknown patterns decode to 0 and flag err.
module seg7_to_bcd
   import seg_scan_capture_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       err
);

   always_comb begin
      digit = 4'd0;
      err   = 1'b0;
      case (seg)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: digit = 4'd0;
         default:   err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Monitors a multiplexed SEG/SEL display bus and rebuilds HH:MM frames from it.
//
//   state  | meaning
//   SCAN   | wait for a one-hot SEL, then latch the sample
//   SETTLE | count consecutive identical samples until the digit is accepted
//   HOLD   | digit accepted for this dwell; wait for the bus to change
module seg_scan_capture
   import seg_scan_capture_pkg::*;
#(
   parameter int STABLE_CYC     = 16,
   parameter int TIMEOUT_CYC    = 500000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1
) (
   input  logic       CLK_50,
   input  logic       CR,
   input  logic       EN,
   input  logic [6:0] SEG,
   input  logic [3:0] SEL,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic       frame_valid,
   output logic       frame_err,
   output logic       time_changed,
   output logic       scan_lost
);

   localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_PRE = TW'(TIMEOUT_CYC - 1);
   // The SCAN cycle supplies the first sample, so SETTLE needs STABLE_CYC-1 more.
   localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYC - 2);

   logic [6:0]       seg_q;
   logic [3:0]       sel_q;
   scan_state_e      state, state_nx;
   logic [6:0]       smp_seg;
   logic [3:0]       smp_sel;
   logic [7:0]       stab_cnt;
   logic [3:0]       mask;
   logic [3:0]       pos_err;
   logic [3:0][3:0]  pos_dig;
   logic [TW-1:0]    tmo_cnt;
   logic             have_frame;

   logic             sel_onehot, same, load, accept, cnt_inc, publish;
   logic [1:0]       acc_idx;
   logic [3:0]       dec_digit;
   logic             dec_err;
   logic [7:0]       new_hour, new_min;

   seg7_to_bcd u_dec (
      .seg   (smp_seg),
      .digit (dec_digit),
      .err   (dec_err)
   );

   assign sel_onehot = is_onehot(sel_q);
   assign same       = (sel_q == smp_sel) && (seg_q == smp_seg);
   assign acc_idx    = onehot_idx(smp_sel);
   assign publish    = EN && (mask == 4'b1111);
   assign new_hour   = {pos_dig[POS_HOUR_T], pos_dig[POS_HOUR_U]};
   assign new_min    = {pos_dig[POS_MIN_T], pos_dig[POS_MIN_U]};

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      accept   = 1'b0;
      cnt_inc  = 1'b0;
      if (EN) begin
         case (state)
            SCAN: begin
               if (sel_onehot) begin
                  load     = 1'b1;
                  state_nx = SETTLE;
               end
            end
            SETTLE: begin
               if (!sel_onehot || !same) begin
                  state_nx = SCAN;
               end else begin
                  cnt_inc = 1'b1;
                  if (stab_cnt == STAB_LAST) begin
                     accept   = 1'b1;
                     state_nx = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!same) state_nx = SCAN;
            end
            default: state_nx = SCAN;
         endcase
      end
   end

   always_ff @(posedge CLK_50 or posedge CR) begin
      if (CR) begin
         seg_q        <= '0;
         sel_q        <= '0;
         state        <= SCAN;
         smp_seg      <= '0;
         smp_sel      <= '0;
         stab_cnt     <= '0;
         mask         <= '0;
         pos_err      <= '0;
         pos_dig      <= '0;
         tmo_cnt      <= '0;
         have_frame   <= 1'b0;
         hour_bcd     <= 8'h00;
         min_bcd      <= 8'h00;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
         time_changed <= 1'b0;
         scan_lost    <= 1'b0;
      end else begin
         seg_q        <= SEG_ACTIVE_LOW ? ~SEG : SEG;
         sel_q        <= SEL_ACTIVE_LOW ? ~SEL : SEL;
         frame_valid  <= 1'b0;
         time_changed <= 1'b0;
         if (EN) begin
            state <= state_nx;
            if (load) begin
               smp_seg  <= seg_q;
               smp_sel  <= sel_q;
               stab_cnt <= '0;
            end else if (cnt_inc) begin
               stab_cnt <= stab_cnt + 8'd1;
            end
            if (accept) begin
               pos_dig[acc_idx] <= dec_digit;
               pos_err[acc_idx] <= dec_err;
               mask[acc_idx]    <= 1'b1;
            end
            if (publish) begin
               hour_bcd     <= new_hour;
               min_bcd      <= new_min;
               frame_valid  <= 1'b1;
               frame_err    <= (|pos_err) || (new_hour > 8'h23) || (new_min > 8'h59);
               time_changed <= !have_frame || ({new_hour, new_min} != {hour_bcd, min_bcd});
               have_frame   <= 1'b1;
               mask         <= '0;
               pos_err      <= '0;
               tmo_cnt      <= '0;
               scan_lost    <= 1'b0;
            end else if (tmo_cnt != TMO_MAX) begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_cnt == TMO_PRE) scan_lost <= 1'b1;
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: drives an active-low scanned display bus
// and checks published frames against a queue of expected frames.
module tb_seg_scan_capture;

   localparam int STABLE = 16;
   localparam int TMO    = 1000;
   localparam int DW     = 64;

   logic       CLK_50 = 1'b0;
   logic       CR, EN;
   logic [6:0] SEG;
   logic [3:0] SEL;
   logic [7:0] hour_bcd, min_bcd;
   logic       frame_valid, frame_err, time_changed, scan_lost;

   always #5 CLK_50 = ~CLK_50;

   seg_scan_capture #(
      .STABLE_CYC     (STABLE),
      .TIMEOUT_CYC    (TMO),
      .SEG_ACTIVE_LOW (1'b1),
      .SEL_ACTIVE_LOW (1'b1)
   ) dut (
      .CLK_50       (CLK_50),
      .CR           (CR),
      .EN           (EN),
      .SEG          (SEG),
      .SEL          (SEL),
      .hour_bcd     (hour_bcd),
      .min_bcd      (min_bcd),
      .frame_valid  (frame_valid),
      .frame_err    (frame_err),
      .time_changed (time_changed),
      .scan_lost    (scan_lost)
   );

   typedef struct packed {
      logic [7:0] h;
      logic [7:0] m;
      logic       e;
      logic       c;
   } exp_t;

   int          errors    = 0;
   int          checks    = 0;
   int          frame_cnt = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   bit          have_pub  = 1'b0;
   logic [15:0] last_pub  = 16'h0000;
   logic [6:0]  code[10]  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // Scoreboard side: every published frame is popped and compared here.
   always @(negedge CLK_50) begin
      if (frame_valid) begin
         frame_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got %h:%h with nothing expected", hour_bcd, min_bcd);
         end else begin
            mon_e = sb.pop_front();
            checks += 3;
            if (hour_bcd !== mon_e.h) begin
               errors++;
               $display("FAIL frame_hour: got %h expected %h", hour_bcd, mon_e.h);
            end
            if (min_bcd !== mon_e.m) begin
               errors++;
               $display("FAIL frame_min: got %h expected %h", min_bcd, mon_e.m);
            end
            if (frame_err !== mon_e.e) begin
               errors++;
               $display("FAIL frame_err: got %b expected %b", frame_err, mon_e.e);
            end
            if (time_changed !== mon_e.c) begin
               errors++;
               $display("FAIL time_changed: got %b expected %b", time_changed, mon_e.c);
            end
         end
      end else if (time_changed) begin
         checks++;
         errors++;
         $display("FAIL stray_time_changed: got 1 expected 0 without frame_valid");
      end
   end

   task automatic set_bus(input int pos, input logic [6:0] pat);
      if (pos < 0) begin
         SEL = 4'hF;
         SEG = 7'h7F;
      end else begin
         SEL = ~(4'b0001 << pos);
         SEG = ~pat;
      end
   endtask

   task automatic dwell(input int pos, input logic [6:0] pat, input int n);
      set_bus(pos, pat);
      repeat (n) begin
         @(posedge CLK_50);
         #1;
      end
   endtask

   task automatic expect_frame(input logic [7:0] h, input logic [7:0] m, input logic e);
      exp_t x;
      x.h = h;
      x.m = m;
      x.e = e;
      x.c = !have_pub || ({h, m} != last_pub);
      have_pub = 1'b1;
      last_pub = {h, m};
      sb.push_back(x);
   endtask

   task automatic scan_round(input logic [6:0] p3, input logic [6:0] p2,
                             input logic [6:0] p1, input logic [6:0] p0);
      dwell(3, p3, DW);
      dwell(2, p2, DW);
      dwell(1, p1, DW);
      dwell(0, p0, DW);
   endtask

   task automatic test_reset;
      CR = 1'b1;
      EN = 1'b1;
      set_bus(-1, 7'h00);
      repeat (3) @(posedge CLK_50);
      #1;
      checks += 6;
      if (hour_bcd !== 8'h00)    begin errors++; $display("FAIL reset_hour: got %h expected 00", hour_bcd); end
      if (min_bcd !== 8'h00)     begin errors++; $display("FAIL reset_min: got %h expected 00", min_bcd); end
      if (frame_valid !== 1'b0)  begin errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
      if (frame_err !== 1'b0)    begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
      if (time_changed !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b expected 0", time_changed); end
      if (scan_lost !== 1'b0)    begin errors++; $display("FAIL reset_lost: got %b expected 0", scan_lost); end
      CR = 1'b0;
      @(posedge CLK_50);
      #1;
   endtask

   task automatic test_ideal_scan;
      int start;
      start = frame_cnt;
      expect_frame(8'h12, 8'h34, 1'b0);
      scan_round(code[1], code[2], code[3], code[4]);
      expect_frame(8'h12, 8'h34, 1'b0);
      scan_round(code[1], code[2], code[3], code[4]);
      dwell(-1, 7'h00, 8);
      checks += 2;
      if (frame_cnt !== start + 2) begin errors++; $display("FAIL ideal_frame_count: got %0d expected %0d", frame_cnt - start, 2); end
      if (scan_lost !== 1'b0)      begin errors++; $display("FAIL ideal_lost: got %b expected 0", scan_lost); end
   endtask

   task automatic test_blank_digit;
      expect_frame(8'h09, 8'h05, 1'b0);
      scan_round(7'h00, code[9], code[0], code[5]);
      dwell(-1, 7'h00, 8);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL blank_pending: got %0d expected 0", sb.size()); end
   endtask

   task automatic test_short_dwell;
      int start;
      start = frame_cnt;
      dwell(3, code[1], DW);
      dwell(2, code[7], DW);
      dwell(1, code[4], STABLE - 1);
      dwell(0, code[2], DW);
      dwell(-1, 7'h00, 8);
      checks++;
      if (frame_cnt !== start) begin errors++; $display("FAIL short_dwell_frame: got %0d frames expected 0", frame_cnt - start); end
      expect_frame(8'h17, 8'h42, 1'b0);
      dwell(1, code[4], DW);
      dwell(-1, 7'h00, 8);
      checks++;
      if (frame_cnt !== start + 1) begin errors++; $display("FAIL short_dwell_complete: got %0d frames expected 1", frame_cnt - start); end
   endtask

   task automatic test_corrupt_digit;
      expect_frame(8'h23, 8'h50, 1'b1);
      scan_round(code[2], code[3], code[5], 7'h49);
      expect_frame(8'h23, 8'h59, 1'b0);
      scan_round(code[2], code[3], code[5], code[9]);
      dwell(-1, 7'h00, 8);
      checks += 2;
      if (frame_err !== 1'b0) begin errors++; $display("FAIL corrupt_err_cleared: got %b expected 0", frame_err); end
      if (sb.size() != 0)     begin errors++; $display("FAIL corrupt_pending: got %0d expected 0", sb.size()); end
   endtask

   task automatic test_enable_freeze;
      int start;
      start = frame_cnt;
      EN = 1'b0;
      scan_round(code[0], code[1], code[0], code[1]);
      checks += 2;
      if (frame_cnt !== start) begin errors++; $display("FAIL en_frame: got %0d frames expected 0", frame_cnt - start); end
      if ({hour_bcd, min_bcd} !== last_pub) begin errors++; $display("FAIL en_hold: got %h%h expected %h", hour_bcd, min_bcd, last_pub); end
      EN = 1'b1;
      dwell(-1, 7'h00, 8);
   endtask

   task automatic test_timeout;
      bit seen;
      seen = 1'b0;
      expect_frame(8'h23, 8'h59, 1'b0);
      dwell(3, code[2], DW);
      dwell(2, code[3], DW);
      dwell(1, code[5], DW);
      set_bus(0, code[9]);
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge CLK_50);
         if (frame_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL timeout_sync: got no frame expected one within 200 cycles"); end
      set_bus(-1, 7'h00);
      repeat (TMO - 10) @(negedge CLK_50);
      checks++;
      if (scan_lost !== 1'b0) begin errors++; $display("FAIL lost_early: got %b expected 0", scan_lost); end
      repeat (20) @(negedge CLK_50);
      checks++;
      if (scan_lost !== 1'b1) begin errors++; $display("FAIL lost_set: got %b expected 1", scan_lost); end
      #1;
      expect_frame(8'h23, 8'h59, 1'b0);
      scan_round(code[2], code[3], code[5], code[9]);
      dwell(-1, 7'h00, 8);
      checks++;
      if (scan_lost !== 1'b0) begin errors++; $display("FAIL lost_clear: got %b expected 0", scan_lost); end
   endtask

   task automatic test_reset_mid_frame;
      int start;
      dwell(3, code[0], DW);
      dwell(2, code[8], DW);
      dwell(1, code[1], DW);
      set_bus(-1, 7'h00);
      @(posedge CLK_50);
      #1;
      CR = 1'b1;
      #1;
      checks += 3;
      if (hour_bcd !== 8'h00)  begin errors++; $display("FAIL cr_hour: got %h expected 00", hour_bcd); end
      if (min_bcd !== 8'h00)   begin errors++; $display("FAIL cr_min: got %h expected 00", min_bcd); end
      if (frame_err !== 1'b0)  begin errors++; $display("FAIL cr_ferr: got %b expected 0", frame_err); end
      repeat (2) @(posedge CLK_50);
      #1;
      CR = 1'b0;
      have_pub = 1'b0;
      last_pub = 16'h0000;
      start = frame_cnt;
      dwell(0, code[6], DW);
      dwell(-1, 7'h00, 8);
      checks++;
      if (frame_cnt !== start) begin errors++; $display("FAIL cr_partial: got %0d frames expected 0", frame_cnt - start); end
      expect_frame(8'h08, 8'h16, 1'b0);
      scan_round(code[0], code[8], code[1], code[6]);
      dwell(-1, 7'h00, 8);
      checks++;
      if (frame_cnt !== start + 1) begin errors++; $display("FAIL cr_refill: got %0d frames expected 1", frame_cnt - start); end
   endtask

   initial begin
      test_reset;
      test_ideal_scan;
      test_blank_digit;
      test_short_dwell;
      test_corrupt_digit;
      test_enable_freeze;
      test_timeout;
      test_reset_mid_frame;
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL final_pending: got %0d expected 0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the clock's multiplexed 7-segment display bus (SEG/SEL).
- Watches the scanned SEG/SEL outputs and decodes the segment patterns back to BCD. Rebuilds a complete HH:MM frame from the four scan positions.
- Used as an on-chip self-check monitor and as the capture front end for the verification harness. Sits beside the display driver on the same CLK_50 domain.

Parameters:
- STABLE_CYC, 16: consecutive identical SEL/SEG samples required before a digit is accepted (range 2..255).
- TIMEOUT_CYC, 500000: cycles without a completed frame before scan_lost asserts.
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when its SEG bit is 0.
- SEL_ACTIVE_LOW, 1: 1 means a digit is selected when its SEL bit is 0.

Ports:
- CLK_50  in  1  system clock
- CR  in  1  reset; asynchronous, active-high (already decided)
- EN  in  1  capture enable; 0 freezes the FSM and outputs and clears the timeout counter
- SEG  in  7  segment bus, SEG[6]=g … SEG[0]=a
- SEL  in  4  digit select; SEL[3]=hour tens, SEL[2]=hour units, SEL[1]=min tens, SEL[0]=min units
- hour_bcd  out  8  captured hours, {tens,units}
- min_bcd  out  8  captured minutes, {tens,units}
- frame_valid  out  1  one-cycle pulse when a new frame is published
- frame_err  out  1  qualifies frame_valid: frame contained an undecodable digit or was out of range
- time_changed  out  1  one-cycle pulse, coincident with frame_valid, when the frame differs from the previous published frame
- scan_lost  out  1  level; no frame completed within TIMEOUT_CYC

Behaviour:
- Reset values: hour_bcd=8'h00, min_bcd=8'h00, all flags 0, FSM=SCAN, position mask 0, stability and timeout counters 0.
- Input registering:
  - SEG and SEL are registered once and normalised to active-high using the parameters.
  - All decisions use the registered copy, so there is 1 cycle of input latency.
- Segment decode (normalised gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 (blank) decodes to 0 and is not an error.
  - Any other pattern decodes to 0 and sets that position's error bit.
- FSM states:
  - SCAN: waits for normalised SEL to be exactly one-hot. Then loads the sample, clears the stability counter and goes to SETTLE.
  - SETTLE: each cycle the sample matches, the counter increments. At count == STABLE_CYC-1, the digit is written to its position register, the mask bit is set, and the FSM goes to HOLD.
    - A change in SEL or SEG returns the FSM to SCAN on the same cycle (the new sample is re-evaluated next cycle).
    - Non-one-hot SEL (zero or multiple bits, i.e. ghosting or blanking interval) also returns to SCAN and is never an error.
  - HOLD: stays until the sample changes, then goes to SCAN. This gives at most one acceptance per dwell.
- Frame completion:
  - When the mask reaches 4'b1111, on the cycle after the fourth acceptance: hour_bcd and min_bcd update, frame_valid pulses, the mask clears, and the timeout counter clears.
  - frame_err = any position error bit, OR hour_bcd > 8'h23, OR min_bcd > 8'h59. It is held until the next frame_valid.
  - time_changed pulses if {hour_bcd,min_bcd} differs from the previous published value.
  - On the first frame after reset, time_changed always pulses.
- Re-acceptance: re-accepting an already-captured position before the frame completes overwrites that position. The mask is unchanged and no error is raised.
- Timeout:
  - The counter increments every enabled cycle and saturates.
  - At TIMEOUT_CYC, scan_lost is set.
  - scan_lost clears on the next frame_valid.
- EN=0: state and registers hold, the timeout counter clears, and no pulses are generated.
- CR mid-operation returns everything to the reset values immediately, including a partially collected mask.

Decomposition:
- Shared package holds:
  - seven-segment code constants SEG_0..SEG_9 and SEG_BLANK (also used by the display encoder);
  - the FSM state enum {SCAN, SETTLE, HOLD};
  - SEL position indices.
- One natural sub-module: seg7_to_bcd (combinational pattern to {digit[3:0], err}).

Test Plan:
- Ideal scan of 12:34, 64-cycle dwell per digit, active-low buses → frame_valid once per scan round, hour_bcd=8'h12, min_bcd=8'h34, frame_err=0, time_changed=1 on the first frame only.
- Hour-tens blank (SEG=7'h7F active-low) with 9:05 → hour_bcd=8'h09, min_bcd=8'h05, frame_err=0.
- Dwell of STABLE_CYC-1 cycles on SEL[1], then SEL moves on → min tens not accepted, no frame_valid until a full-length dwell occurs.
- Corrupt pattern 7'h49 on min units → frame_valid with frame_err=1; a subsequent clean 23:59 frame clears frame_err and pulses time_changed.
- Stop toggling SEL for TIMEOUT_CYC (set to 1000 in the bench) → scan_lost=1 at cycle 1000; it clears on the next completed frame.
- Assert CR after three digits are captured → all outputs 0 immediately, and the next frame needs all four digits again.
